// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer
// Brief    : Synchronises and debounces N raw slide switches and emits a
//            one-cycle change pulse on every accepted level change.
// Revision : 1.0 - initial release
// ============================================================================
module switch_debouncer #(
    parameter int N             = 10,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sw_raw,
    output logic [N-1:0] switches,
    output logic [N-1:0] sw_changed
);

    localparam int                 C_CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic [SYNC_STAGES-1:0] r_sync;
        logic [C_CNT_W-1:0]     r_cnt;
        logic                   r_level;
        logic                   r_pulse;
        logic                   w_sync;
        logic                   w_differs;
        logic                   w_expired;

        assign w_sync    = r_sync[SYNC_STAGES-1];
        assign w_differs = w_sync ^ r_level;
        assign w_expired = (r_cnt == C_CNT_LAST);

        // The count only advances while the synchronised level disagrees with
        // the accepted level, so any return to the old level restarts it.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync  <= '0;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_pulse <= 1'b0;
            end else begin
                r_sync  <= {r_sync[SYNC_STAGES-2:0], sw_raw[i]};
                r_pulse <= 1'b0;
                if (!w_differs) begin
                    r_cnt <= '0;
                end else if (w_expired) begin
                    r_level <= w_sync;
                    r_pulse <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + C_CNT_ONE;
                end
            end
        end

        assign switches[i]   = r_level;
        assign sw_changed[i] = r_pulse;
    end

endmodule
`default_nettype wire
